// File: rtl/npu_load_sequencer.sv
// Load sequencer: accepts region load commands, then streams data beats into the
// PE buffer at region-relative, wrapping addresses with a registered write port.
module npu_load_sequencer #(
    parameter int N               = 10,
    parameter int K_SIZE          = 3,
    parameter int W_IN            = 8,
    parameter int SEL_DEMUX_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_region,
    input  logic [5:0]                 cmd_len,
    input  logic                       ptr_clr,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic [W_IN-1:0]            data_in,
    output logic                       buffer_wen,
    output logic [W_IN-1:0]            buffer_wdata,
    output logic [SEL_DEMUX_WIDTH-1:0] pe_demux_sel,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int DEPTH_AB = N * K_SIZE;
    localparam int DEPTH_C  = K_SIZE;
    localparam int PTR_W    = (DEPTH_AB > 1) ? $clog2(DEPTH_AB) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                              state_q, state_d;
    logic [1:0]                          region_q, region_d;
    logic [5:0]                          cnt_q, cnt_d;
    // Indexed directly by region code; entry 0 is never written.
    logic [3:0][PTR_W-1:0]               ptr_q, ptr_d;
    logic                                wen_q, wen_d;
    logic [W_IN-1:0]                     wdata_q, wdata_d;
    logic [SEL_DEMUX_WIDTH-1:0]          sel_q, sel_d;
    logic                                err_q, err_d;
    logic                                cmd_ok;
    logic [PTR_W-1:0]                    cur_ptr;

    function automatic int unsigned depth_of(input logic [1:0] r);
        case (r)
            2'd1, 2'd2: depth_of = DEPTH_AB;
            2'd3:       depth_of = DEPTH_C;
            default:    depth_of = 0;
        endcase
    endfunction

    function automatic logic [SEL_DEMUX_WIDTH-1:0] start_of(input logic [1:0] r);
        case (r)
            2'd2:    start_of = SEL_DEMUX_WIDTH'(DEPTH_AB);
            2'd3:    start_of = SEL_DEMUX_WIDTH'(2 * DEPTH_AB);
            default: start_of = '0;
        endcase
    endfunction

    assign cmd_ready  = (state_q == IDLE) && !ptr_clr;
    assign data_ready = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign cmd_ok     = (cmd_region != 2'd0) && (cmd_len != 6'd0) &&
                        (32'(cmd_len) <= depth_of(cmd_region));
    assign cur_ptr    = ptr_q[region_q];

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        wen_d    = 1'b0;
        wdata_d  = '0;
        sel_d    = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // ptr_clr also masks cmd_ready, so it takes priority over a command.
                if (ptr_clr) begin
                    ptr_d = '0;
                end else if (cmd_valid) begin
                    if (cmd_ok) begin
                        state_d  = LOAD;
                        region_d = cmd_region;
                        cnt_d    = cmd_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (data_valid) begin
                    wen_d   = 1'b1;
                    wdata_d = data_in;
                    sel_d   = start_of(region_q) + SEL_DEMUX_WIDTH'(cur_ptr);
                    if (32'(cur_ptr) == depth_of(region_q) - 1)
                        ptr_d[region_q] = '0;
                    else
                        ptr_d[region_q] = cur_ptr + PTR_W'(1);
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1)
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            region_q <= 2'd0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
        end
    end

    assign buffer_wen   = wen_q;
    assign buffer_wdata = wdata_q;
    assign pe_demux_sel = sel_q;
    assign err          = err_q;

endmodule

// File: tb/tb_npu_load_sequencer.sv
// Directed bench for npu_load_sequencer: per-scenario tasks compare logged
// buffer writes and control outputs against hand-computed values.
module tb_npu_load_sequencer;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, ptr_clr;
    logic [1:0] cmd_region;
    logic [5:0] cmd_len;
    logic       data_valid, data_ready;
    logic [7:0] data_in, buffer_wdata;
    logic       buffer_wen, busy, done, err;
    logic [5:0] pe_demux_sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] log_sel[$];
    logic [7:0] log_dat[$];
    logic       log_done[$];
    int done_cnt  = 0;
    int err_cnt   = 0;
    int zero_viol = 0;

    npu_load_sequencer #(.N(10), .K_SIZE(3), .W_IN(8), .SEL_DEMUX_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_region(cmd_region), .cmd_len(cmd_len), .ptr_clr(ptr_clr),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .buffer_wen(buffer_wen), .buffer_wdata(buffer_wdata),
        .pe_demux_sel(pe_demux_sel), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/pulse logger; sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (buffer_wen === 1'b1) begin
            log_sel.push_back(pe_demux_sel);
            log_dat.push_back(buffer_wdata);
            log_done.push_back(done);
        end else if (buffer_wen === 1'b0 && (pe_demux_sel !== 6'd0 || buffer_wdata !== 8'd0)) begin
            zero_viol++;
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1)  err_cnt++;
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] r, input logic [5:0] l);
        nstep();
        cmd_valid = 1'b1; cmd_region = r; cmd_len = l;
        nstep();
        cmd_valid = 1'b0; cmd_region = 2'd0; cmd_len = 6'd0;
    endtask

    task automatic send_beats(input int n, input logic [7:0] d0);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1; data_in = d0 + 8'(i);
            nstep();
        end
        data_valid = 1'b0; data_in = 8'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 0; cmd_region = 0; cmd_len = 0;
        ptr_clr = 0; data_valid = 0; data_in = 0;
        repeat (2) @(posedge clk);
        nstep();
        rst_n = 1'b1;
        nstep();
        n_checks++; if (buffer_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b exp 0", buffer_wen); end
        n_checks++; if (buffer_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 00", buffer_wdata); end
        n_checks++; if (pe_demux_sel !== 6'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", pe_demux_sel); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready got %b exp 0", data_ready); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] es[6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
        logic [7:0] ed[6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22};
        logic       ef[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int base = log_sel.size();
        int d0 = done_cnt;
        send_cmd(2'd1, 6'd4);
        n_checks++; if (busy !== 1'b1 || data_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_load_state got busy=%b data_ready=%b exp 1/1", busy, data_ready); end
        send_beats(4, 8'h11);
        send_cmd(2'd1, 6'd2);
        send_beats(2, 8'h21);
        nstep();
        n_checks++; if (log_sel.size() - base != 6) begin n_fail++; $display("FAIL b2b_count got %0d exp 6", log_sel.size() - base); end
        for (int i = 0; i < 6 && base + i < log_sel.size(); i++) begin
            n_checks++;
            if (log_sel[base+i] !== es[i] || log_dat[base+i] !== ed[i] || log_done[base+i] !== ef[i]) begin
                n_fail++;
                $display("FAIL b2b_write%0d got sel=%0d data=%h done=%b exp sel=%0d data=%h done=%b",
                         i, log_sel[base+i], log_dat[base+i], log_done[base+i], es[i], ed[i], ef[i]);
            end
        end
        n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_pulses got %0d exp 2", done_cnt - d0); end
    endtask

    task automatic test_c_wrap();
        logic [5:0] es[5] = '{6'd60, 6'd61, 6'd62, 6'd60, 6'd61};
        int base = log_sel.size();
        send_cmd(2'd3, 6'd3);
        send_beats(3, 8'h30);
        send_cmd(2'd3, 6'd2);
        send_beats(2, 8'h40);
        nstep();
        n_checks++; if (log_sel.size() - base != 5) begin n_fail++; $display("FAIL cwrap_count got %0d exp 5", log_sel.size() - base); end
        for (int i = 0; i < 5 && base + i < log_sel.size(); i++) begin
            n_checks++;
            if (log_sel[base+i] !== es[i]) begin
                n_fail++; $display("FAIL cwrap_sel%0d got %0d exp %0d", i, log_sel[base+i], es[i]);
            end
        end
    endtask

    task automatic test_b_wrap_clear();
        int base = log_sel.size();
        logic [5:0] exp_s;
        send_cmd(2'd2, 6'd29);
        send_beats(29, 8'h60);
        send_cmd(2'd2, 6'd3);
        send_beats(3, 8'h90);
        nstep();
        n_checks++; if (log_sel.size() - base != 32) begin n_fail++; $display("FAIL bwrap_count got %0d exp 32", log_sel.size() - base); end
        for (int i = 0; i < 32 && base + i < log_sel.size(); i++) begin
            exp_s = (i < 30) ? 6'(30 + i) : 6'(i);
            n_checks++;
            if (log_sel[base+i] !== exp_s) begin
                n_fail++; $display("FAIL bwrap_sel%0d got %0d exp %0d", i, log_sel[base+i], exp_s);
            end
        end
        n_checks++; if (log_dat[base+31] !== 8'h92) begin n_fail++; $display("FAIL bwrap_last_data got %h exp 92", log_dat[base+31]); end
        ptr_clr = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ptrclr_cmd_ready got %b exp 0", cmd_ready); end
        nstep();
        ptr_clr = 1'b0;
        base = log_sel.size();
        send_cmd(2'd2, 6'd1);
        send_beats(1, 8'hB1);
        send_cmd(2'd1, 6'd1);
        send_beats(1, 8'hA1);
        nstep();
        n_checks++; if (log_sel.size() - base != 2) begin n_fail++; $display("FAIL ptrclr_count got %0d exp 2", log_sel.size() - base); end
        n_checks++; if (log_sel[base] !== 6'd30) begin n_fail++; $display("FAIL ptrclr_b_sel got %0d exp 30", log_sel[base]); end
        n_checks++; if (log_sel[base+1] !== 6'd0) begin n_fail++; $display("FAIL ptrclr_a_sel got %0d exp 0", log_sel[base+1]); end
    endtask

    task automatic test_stall();
        int base = log_sel.size();
        send_cmd(2'd1, 6'd2);
        data_valid = 1'b1; data_in = 8'h41;
        nstep();
        data_valid = 1'b0; data_in = 8'h00;
        nstep();
        n_checks++; if (buffer_wen !== 1'b0 || busy !== 1'b1 || data_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL stall_gap1 got wen=%b busy=%b rdy=%b done=%b exp 0/1/1/0", buffer_wen, busy, data_ready, done); end
        nstep();
        n_checks++; if (buffer_wen !== 1'b0 || busy !== 1'b1 || data_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL stall_gap2 got wen=%b busy=%b rdy=%b done=%b exp 0/1/1/0", buffer_wen, busy, data_ready, done); end
        data_valid = 1'b1; data_in = 8'h42;
        nstep();
        data_valid = 1'b0; data_in = 8'h00;
        n_checks++; if (buffer_wen !== 1'b1 || done !== 1'b1 || pe_demux_sel !== 6'd2 || buffer_wdata !== 8'h42) begin
            n_fail++; $display("FAIL stall_last got wen=%b done=%b sel=%0d data=%h exp 1/1/2/42", buffer_wen, done, pe_demux_sel, buffer_wdata); end
        nstep();
        n_checks++; if (log_sel.size() - base != 2) begin n_fail++; $display("FAIL stall_count got %0d exp 2", log_sel.size() - base); end
        n_checks++; if (log_sel[base] !== 6'd1 || log_dat[base] !== 8'h41) begin
            n_fail++; $display("FAIL stall_first got sel=%0d data=%h exp 1/41", log_sel[base], log_dat[base]); end
    endtask

    task automatic test_invalid();
        logic [1:0] rr[4] = '{2'd0, 2'd1, 2'd3, 2'd1};
        logic [5:0] ll[4] = '{6'd5, 6'd31, 6'd4, 6'd0};
        int base = log_sel.size();
        int e0;
        for (int i = 0; i < 4; i++) begin
            e0 = err_cnt;
            send_cmd(rr[i], ll[i]);
            n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL invalid%0d_pulse got err=%b busy=%b exp 1/0", i, err, busy); end
            nstep();
            n_checks++; if (err !== 1'b0 || busy !== 1'b0 || err_cnt - e0 != 1) begin
                n_fail++; $display("FAIL invalid%0d_after got err=%b busy=%b pulses=%0d exp 0/0/1", i, err, busy, err_cnt - e0); end
        end
        data_valid = 1'b1; data_in = 8'hEE;
        #1;
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL idle_data_ready got %b exp 0", data_ready); end
        nstep();
        data_valid = 1'b0; data_in = 8'h00;
        nstep();
        n_checks++; if (log_sel.size() != base) begin n_fail++; $display("FAIL invalid_no_write got %0d writes exp 0", log_sel.size() - base); end
        send_cmd(2'd1, 6'd1);
        send_beats(1, 8'h55);
        nstep();
        n_checks++; if (log_sel.size() != base + 1 || log_sel[base] !== 6'd3) begin
            n_fail++; $display("FAIL invalid_ptr_kept got sel=%0d exp 3", log_sel[base]); end
    endtask

    task automatic test_reset_midload();
        int base = log_sel.size();
        int d0 = done_cnt;
        send_cmd(2'd1, 6'd5);
        send_beats(2, 8'h51);
        rst_n = 1'b0; data_valid = 1'b1; data_in = 8'h53;
        nstep();
        nstep();
        rst_n = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        nstep();
        n_checks++; if (busy !== 1'b0 || buffer_wen !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_idle got busy=%b wen=%b cmd_ready=%b exp 0/0/1", busy, buffer_wen, cmd_ready); end
        n_checks++; if (log_sel.size() - base != 2 || done_cnt != d0) begin
            n_fail++; $display("FAIL midrst_abandon got writes=%0d dones=%0d exp 2/0", log_sel.size() - base, done_cnt - d0); end
        send_cmd(2'd1, 6'd1);
        send_beats(1, 8'h61);
        nstep();
        n_checks++; if (log_sel.size() - base != 3 || log_sel[base+2] !== 6'd0 || log_done[base+2] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_next got sel=%0d done=%b exp 0/1", log_sel[base+2], log_done[base+2]); end
        n_checks++; if (log_sel[base] !== 6'd4 || log_sel[base+1] !== 6'd5) begin
            n_fail++; $display("FAIL midrst_partial got %0d,%0d exp 4,5", log_sel[base], log_sel[base+1]); end
        n_checks++; if (zero_viol != 0) begin n_fail++; $display("FAIL idle_outputs_zero got %0d violations exp 0", zero_viol); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_c_wrap();
        test_b_wrap_clear();
        test_stall();
        test_invalid();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/npu_load_sequencer.md
NPU_LOAD_SEQUENCER -- requirements
Module: npu_load_sequencer

Interface
REQ-001 SHALL have parameter N, default 10, the number of PE columns.
REQ-002 SHALL have parameter K_SIZE, default 3, the kernel edge.
REQ-003 SHALL have parameter W_IN, default 8, the data word width.
REQ-004 SHALL have parameter SEL_DEMUX_WIDTH, default 6, the buffer demux select width.
REQ-005 SHALL have port clk, input, 1 bit, the single work clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset, synchronous and active-low.
REQ-007 SHALL have port cmd_valid, input, 1 bit, command offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit, command accepted when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_region, input, 2 bits: 1=A, 2=B, 3=C, 0=invalid.
REQ-010 SHALL have port cmd_len, input, 6 bits, number of data beats in the command.
REQ-011 SHALL have port ptr_clr, input, 1 bit, clears all region pointers.
REQ-012 SHALL have port data_valid, input, 1 bit, data beat offered.
REQ-013 SHALL have port data_ready, output, 1 bit, beat accepted when data_valid && data_ready.
REQ-014 SHALL have port data_in, input, W_IN bits, beat payload.
REQ-015 SHALL have port buffer_wen, output, 1 bit, buffer write strobe.
REQ-016 SHALL have port buffer_wdata, output, W_IN bits, write data.
REQ-017 SHALL have port pe_demux_sel, output, SEL_DEMUX_WIDTH bits, write address.
REQ-018 SHALL have port busy, output, 1 bit, high when the state is not IDLE.
REQ-019 SHALL have port done, output, 1 bit, one-cycle pulse.
REQ-020 SHALL have port err, output, 1 bit, one-cycle pulse.

Function
REQ-021 SHALL implement the states IDLE, LOAD and DONE.
- Transitions: IDLE->LOAD on a valid command accepted; LOAD->DONE on the last beat accepted; DONE->IDLE unconditionally.
REQ-022 SHALL define the region layout as follows.
- Depths: A = N*K_SIZE (30), B = N*K_SIZE (30), C = K_SIZE (3).
- Start addresses: A = 0, B = 30, C = 60.
REQ-023 SHALL drive cmd_ready = (state==IDLE) && !ptr_clr.
REQ-024 SHALL drive data_ready = (state==LOAD).
REQ-025 SHALL treat a command as valid only when cmd_region!=0 and 1 <= cmd_len <= depth(region).
REQ-026 SHALL handle an accepted invalid command as follows.
- err=1 on the next cycle.
- State stays IDLE.
- No writes occur and pointers are unchanged.
REQ-027 SHALL latch the region and remaining-beat count on acceptance of a valid command.
REQ-028 SHALL keep one pointer per region that persists across commands.
- Each accepted beat increments the active region's pointer.
- The pointer wraps from depth-1 to 0.
REQ-029 SHALL register each accepted beat for the next cycle.
- buffer_wen=1.
- buffer_wdata=data_in.
- pe_demux_sel=start(region)+pointer value before the increment.
- Latency is exactly 1 cycle; buffer_wen=0 when no beat was accepted.
REQ-030 SHALL tolerate data_valid gaps in LOAD; the state and count hold with no write.
REQ-031 SHALL assert done in the DONE cycle, coincident with buffer_wen of the last beat.
REQ-032 SHALL, on ptr_clr=1 in IDLE, zero all three pointers at the next edge; ptr_clr is ignored in LOAD and DONE.
REQ-033 SHALL ignore data_valid outside LOAD; no write and no acceptance occur.
REQ-034 SHALL drive pe_demux_sel and buffer_wdata to 0 whenever buffer_wen=0.

Reset
REQ-035 SHALL, when rst_n=0 at a rising edge, apply the following.
- State becomes IDLE.
- All pointers and the count become 0.
- buffer_wen, buffer_wdata, pe_demux_sel, done, err and busy become 0.
REQ-036 SHALL, on reset during LOAD, abandon the command; remaining beats are not written and no done pulse is issued.
REQ-037 SHALL present cmd_ready=1 on the first cycle after reset release when ptr_clr=0.

Verification
REQ-038 SHALL cover reset and idle: hold rst_n=0 for 2 cycles, then release -> all outputs 0, cmd_ready=1, busy=0.
REQ-039 SHALL cover back-to-back loads of A.
- Stimulus: A len 4 with data 0x11..0x14 streamed continuously, then A len 2 with data 0x21..0x22.
- Response: writes at sel 0,1,2,3 with matching data; done coincides with the write at sel 3; second command writes sel 4,5.
REQ-040 SHALL cover C wrap: C len 3, then C len 2 -> sel 60,61,62, then 60,61.
REQ-041 SHALL cover B wrap and pointer clear.
- B len 29, then B len 3 -> sel 30..58, then 59,30,31.
- ptr_clr in IDLE, then B len 1 -> sel 30.
REQ-042 SHALL cover stalls and invalid commands.
- Stall: data_valid toggled 1,0,0,1 in LOAD -> only 2 writes, count and state held during the gaps.
- Invalid commands: region 0; A len 31; C len 4; len 0 -> each gives one err pulse, no buffer_wen, busy=0.
REQ-043 SHALL cover reset mid-load: A len 5 with 2 beats accepted, then rst_n=0 -> no further writes, no done; next A len 1 writes sel 0.
